adder_arb_32: RTL and testbench

ADDER_ARB_32 -- requirements
Module: adder_arb_32

---
 rtl/adder_arb_pkg.sv | 14 +
 rtl/carry_select_adder_32.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/adder_arb_32.sv | 107 ++++++++++
 tb/tb_adder_arb_32.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared defaults and FSM state type for the arbitrated 32-bit adder.
package adder_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned ID_W        = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/carry_select_adder_32.sv
// 32-bit carry-select adder: four 8-bit blocks, each precomputing both carry-in cases.
module carry_select_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [8:0] s0 [4];
    logic [8:0] s1 [4];
    logic       carry;

    for (genvar k = 0; k < 4; k++) begin : g_blk
        assign s0[k] = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]};
        assign s1[k] = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]} + 9'd1;
    end

    // Carry ripples only through the block-level selects.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int k = 0; k < 4; k++) begin
            {carry, sum[8*k +: 8]} = carry ? s1[k] : s0[k];
        end
        cout = carry;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic           found;
    int unsigned    j;
    logic [IDW-1:0] jj;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j  = (32'(ptr) + i) % N;
            jj = IDW'(j);
            if (!found && req[jj]) begin
                found     = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

endmodule

// File: rtl/adder_arb_32.sv
// Round-robin arbitrated 32-bit adder shared by NUM_REQ requesters.
// Define ADDER_ARB_OVF_EN to add the registered signed-overflow output res_ovf.
module adder_arb_32
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout,
`ifdef ADDER_ARB_OVF_EN
    output logic                     res_ovf,
`endif
    output logic [IdW-1:0]           res_id
);

    state_t           state;
    logic [IdW-1:0]   rr_ptr;
    logic [IdW-1:0]   op_id;
    logic [IdW-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IdW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    assign req_ready = (rst_n && state == IDLE) ? gnt : '0;

    carry_select_adder_32 u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
`ifdef ADDER_ARB_OVF_EN
            res_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        op_a   <= req_in1[gnt_idx*WIDTH +: WIDTH];
                        op_b   <= req_in2[gnt_idx*WIDTH +: WIDTH];
                        op_cin <= req_cin[gnt_idx];
                        op_id  <= gnt_idx;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    res_sum   <= add_sum;
                    res_cout  <= add_cout;
                    res_id    <= op_id;
`ifdef ADDER_ARB_OVF_EN
                    res_ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                 (add_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= (op_id == IdW'(NUM_REQ - 1)) ? '0 : op_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arb_32.sv
// Self-checking bench for adder_arb_32; expected results flow through a scoreboard queue.
// Honours ADDER_ARB_OVF_EN to also check res_ovf.
module tb_adder_arb_32;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_in1 = '0;
    logic [N*W-1:0] req_in2 = '0;
    logic [N-1:0]   req_cin = '0;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic [1:0]     res_id;
`ifdef ADDER_ARB_OVF_EN
    logic           res_ovf;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    adder_arb_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
`ifdef ADDER_ARB_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .res_id    (res_id)
    );

    function automatic exp_t model(int id, logic [31:0] a, logic [31:0] b, logic c);
        exp_t e;
        logic [32:0] full;
        full   = {1'b0, a} + {1'b0, b} + {32'd0, c};
        e.id   = 2'(id);
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        return e;
    endfunction

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic c);
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
        req_cin[i]        = c;
    endtask

    // Records the grant visible this cycle and pushes its expected result.
    task automatic push_grant(output int gid);
        gid = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        if (gid >= 0)
            sb.push_back(model(gid, req_in1[gid*W +: W], req_in2[gid*W +: W], req_cin[gid]));
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        req_valid = '1;
        @(negedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 32'd0 || res_cout !== 1'b0 || res_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b id=%0d, want 0/0/0/0",
                     res_valid, res_sum, res_cout, res_id);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready: got %b, want 0000", req_ready);
        end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    // One request through the pipe with res_ready=1; checks latency and result.
    task automatic single_flow(string name, int i, logic [31:0] a, logic [31:0] b, logic c);
        int   gid;
        exp_t e;
        @(negedge clk);
        set_req(i, a, b, c);
        req_valid = 4'(1 << i);
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'(1 << i)) begin
            failures++;
            $display("FAIL %s_grant: got req_ready=%b, want %b", name, req_ready, 4'(1 << i));
        end
        push_grant(gid);
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL %s_calc: got valid=%b ready=%b, want 0/0000", name, res_valid, req_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL %s_latency: got valid=%b at t+2 (queued=%0d), want 1",
                     name, res_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
                failures++;
                $display("FAIL %s_result: got sum=%h cout=%b id=%0d, want sum=%h cout=%b id=%0d",
                         name, res_sum, res_cout, res_id, e.sum, e.cout, e.id);
            end
`ifdef ADDER_ARB_OVF_EN
            checks++;
            if (res_ovf !== e.ovf) begin
                failures++;
                $display("FAIL %s_ovf: got %b, want %b", name, res_ovf, e.ovf);
            end
`endif
        end
        @(negedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: got res_valid=%b, want 0", name, res_valid);
        end
    endtask

    task automatic test_single();
        single_flow("single", 0, 32'h0000_0005, 32'h0000_0003, 1'b0);
        checks++;
        if (res_sum !== 32'h8 || res_cout !== 1'b0 || res_id !== 2'd0) begin
            failures++;
            $display("FAIL single_const: got sum=%h cout=%b id=%0d, want 8/0/0",
                     res_sum, res_cout, res_id);
        end
    endtask

    task automatic test_carry();
        single_flow("carry", 2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checks++;
        if (res_sum !== 32'h0 || res_cout !== 1'b1) begin
            failures++;
            $display("FAIL carry_const: got sum=%h cout=%b, want 0/1", res_sum, res_cout);
        end
    endtask

`ifdef ADDER_ARB_OVF_EN
    task automatic test_ovf();
        single_flow("ovf", 0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        checks++;
        if (res_sum !== 32'h8000_0000 || res_ovf !== 1'b1 || res_cout !== 1'b0) begin
            failures++;
            $display("FAIL ovf_const: got sum=%h ovf=%b cout=%b, want 80000000/1/0",
                     res_sum, res_ovf, res_cout);
        end
    endtask
`endif

    task automatic test_round_robin();
        int   exp_order[5] = '{0, 1, 2, 3, 0};
        int   ng = 0;
        int   nr = 0;
        int   last_g = -3;
        int   gid;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < N; i++)
            set_req(i, 32'h1000_0000 * (i + 1) + 32'(i), 32'h0111_0000 * (i + 1), i[0]);
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (cyc == 0) req_valid = '1;
            #1;
            if (req_ready !== 4'b0000) begin
                push_grant(gid);
                checks++;
                if (ng >= 5 || gid != exp_order[ng] || (ng > 0 && cyc - last_g != 3)) begin
                    failures++;
                    $display("FAIL rr_grant: got grant %0d at cycle %0d (#%0d, prev %0d), want %0d every 3",
                             gid, cyc, ng, last_g, (ng < 5) ? exp_order[ng] : -1);
                end
                last_g = cyc;
                ng++;
            end
            if (res_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rr_result: got unexpected result id=%0d, want none", res_id);
                end else begin
                    e = sb.pop_front();
                    if (res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
                        failures++;
                        $display("FAIL rr_result: got sum=%h cout=%b id=%0d, want %h/%b/%0d",
                                 res_sum, res_cout, res_id, e.sum, e.cout, e.id);
                    end
                end
                nr++;
            end
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (ng != 5 || nr != 5) begin
            failures++;
            $display("FAIL rr_count: got %0d grants %0d results, want 5/5", ng, nr);
        end
    endtask

    task automatic test_backpressure();
        int          gid;
        exp_t        e;
        logic [31:0] s;
        logic [1:0]  id;
        @(negedge clk);
        res_ready = 1'b0;
        set_req(1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b1);
        set_req(3, 32'h8000_0001, 32'h8000_0002, 1'b0);
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant: got %b, want 0010", req_ready);
        end
        push_grant(gid);
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_calc: got ready=%b valid=%b, want 0000/0", req_ready, res_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL bp_result: got valid=%b, want 1", res_valid);
        end else begin
            e = sb.pop_front();
            if (res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
                failures++;
                $display("FAIL bp_result: got sum=%h cout=%b id=%0d, want %h/%b/%0d",
                         res_sum, res_cout, res_id, e.sum, e.cout, e.id);
            end
        end
        s  = res_sum;
        id = res_id;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_sum !== s || res_id !== id || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold: got valid=%b sum=%h id=%0d ready=%b, want 1/%h/%0d/0000",
                         res_valid, res_sum, res_id, req_ready, s, id);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL bp_next_grant: got %b, want 1000", req_ready);
        end
        push_grant(gid);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL bp_second: got valid=%b, want 1", res_valid);
        end else begin
            e = sb.pop_front();
            if (res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
                failures++;
                $display("FAIL bp_second: got sum=%h cout=%b id=%0d, want %h/%b/%0d",
                         res_sum, res_cout, res_id, e.sum, e.cout, e.id);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_calc();
        logic stale = 1'b0;
        @(negedge clk);
        set_req(0, 32'h0000_1234, 32'h0000_4321, 1'b1);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_calc_grant: got %b, want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 32'd0 || res_cout !== 1'b0 ||
            res_id !== 2'd0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rst_calc_outputs: got valid=%b sum=%h cout=%b id=%0d ready=%b, want zeros",
                     res_valid, res_sum, res_cout, res_id, req_ready);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (res_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            failures++;
            $display("FAIL rst_calc_stale: got res_valid=1 after release, want 0");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
`ifdef ADDER_ARB_OVF_EN
        test_ovf();
`endif
        test_round_robin();
        test_backpressure();
        test_reset_in_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
